issue_queue: RTL and testbench

- Parametrised in-order instruction buffer between fetch and the multi-lane execute pipelines.
- Generalises the fixed two-lane p0/p1 instruction/PC injection into an N-lane front end.
- Accepts up to ENQ_W instructions per cycle and issues up to ISSUE_W per cycle, oldest first.
- Holds back any lane whose instruction conflicts with an older instruction in the same bundle.

---
 rtl/issue_queue.sv | 172 +++++++++++++++++
 tb/tb_issue_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// issue_queue: in-order circular issue buffer. It accepts ENQ_W lanes per cycle and issues up to ISSUE_W lanes oldest-first, holding back lanes that hazard with older ones.
// Define ISSUEQ_BYPASS_EN to let an empty, unstalled queue issue incoming lanes in the same cycle.
package issue_queue_pkg;
   typedef struct packed {
      logic       dst_v;
      logic [2:0] dst;
      logic       s0_v;
      logic [2:0] s0;
      logic       s1_v;
      logic [2:0] s1;
      logic       wf;
      logic       halt;
   } dec_t;
endpackage

module issue_queue_dec
   import issue_queue_pkg::*;
(
   input  logic [15:0] ir,
   output dec_t        dec
);
   always_comb begin
      dec = '0;
      casez ({ir[15:13], ir[12:11]})
         5'b110_10: begin dec.dst_v = 1'b1; dec.dst = ir[10:8]; end
         5'b110_00: begin
            dec.dst_v = 1'b1; dec.dst = ir[7:5];
            dec.s0_v  = 1'b1; dec.s0  = ir[2:0];
         end
         5'b101_00, 5'b101_10: begin
            dec.dst_v = 1'b1; dec.dst = ir[7:5];
            dec.s0_v  = 1'b1; dec.s0  = ir[10:8];
            dec.s1_v  = 1'b1; dec.s1  = ir[2:0];
         end
         5'b101_01: begin
            dec.s0_v = 1'b1; dec.s0 = ir[10:8];
            dec.s1_v = 1'b1; dec.s1 = ir[2:0];
            dec.wf   = 1'b1;
         end
         5'b101_11: begin
            dec.dst_v = 1'b1; dec.dst = ir[7:5];
            dec.s0_v  = 1'b1; dec.s0  = ir[2:0];
         end
         5'b011_00: begin
            dec.dst_v = 1'b1; dec.dst = ir[7:5];
            dec.s0_v  = 1'b1; dec.s0  = ir[10:8];
         end
         5'b100_00: begin
            dec.s0_v = 1'b1; dec.s0 = ir[10:8];
            dec.s1_v = 1'b1; dec.s1 = ir[7:5];
         end
         5'b111_??: dec.halt = 1'b1;
         default: ;
      endcase
   end
endmodule

module issue_queue
   import issue_queue_pkg::*;
#(
   parameter int ISSUE_W = 2,
   parameter int ENQ_W   = 2,
   parameter int DEPTH   = 8,
   parameter int PC_W    = 8,
   parameter int IR_W    = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         stall,
   input  logic [ENQ_W-1:0]             in_valid,
   input  logic [ENQ_W-1:0][IR_W-1:0]   in_ir,
   input  logic [ENQ_W-1:0][PC_W-1:0]   in_pc,
   output logic                         in_ready,
   output logic [ISSUE_W-1:0]           out_valid,
   output logic [ISSUE_W-1:0][IR_W-1:0] out_ir,
   output logic [ISSUE_W-1:0][PC_W-1:0] out_pc,
   output logic [$clog2(DEPTH):0]       count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [IR_W-1:0]    mem_ir [DEPTH];
   logic [PC_W-1:0]    mem_pc [DEPTH];
   logic [AW-1:0]      head, tail;
   logic               byp, do_enq, run, ok, wf_seen, halt_seen;
   logic [CW-1:0]      n_in, n_iss, skip, n_wr, deq;
   logic [ISSUE_W-1:0] avail;
   logic [7:0]         wmask;
   dec_t [ISSUE_W-1:0] dec;

`ifdef ISSUEQ_BYPASS_EN
   assign byp = (count == '0) && !stall;
`else
   assign byp = 1'b0;
`endif

   // valid lanes counted only up to the first gap; anything above it is dropped
   always_comb begin
      run  = 1'b1;
      n_in = '0;
      for (int j = 0; j < ENQ_W; j++) begin
         run  = run & in_valid[j];
         n_in = n_in + CW'(run);
      end
   end

   for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
      logic [AW-1:0] ent;
      assign ent = head + AW'(k);
      if (k < ENQ_W) begin : g_in
         assign out_ir[k] = byp ? in_ir[k] : mem_ir[ent];
         assign out_pc[k] = byp ? in_pc[k] : mem_pc[ent];
      end else begin : g_st
         assign out_ir[k] = byp ? '0 : mem_ir[ent];
         assign out_pc[k] = byp ? '0 : mem_pc[ent];
      end
      assign avail[k] = byp ? (CW'(k) < n_in) : (CW'(k) < count);
      issue_queue_dec u_dec (.ir(out_ir[k][15:0]), .dec(dec[k]));
   end

   // a lane issues only if every older lane issues and it is hazard-free against all of them
   always_comb begin
      wmask     = '0;
      wf_seen   = 1'b0;
      halt_seen = 1'b0;
      ok        = 1'b1;
      out_valid = '0;
      n_iss     = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         ok = ok && avail[k] && !halt_seen
              && !(dec[k].halt && k != 0)
              && !(dec[k].wf && wf_seen)
              && !(dec[k].s0_v && wmask[dec[k].s0])
              && !(dec[k].s1_v && wmask[dec[k].s1])
              && !(dec[k].dst_v && wmask[dec[k].dst]);
         out_valid[k] = ok;
         n_iss        = n_iss + CW'(ok);
         if (dec[k].dst_v) wmask[dec[k].dst] = 1'b1;
         wf_seen   = wf_seen | dec[k].wf;
         halt_seen = halt_seen | dec[k].halt;
      end
   end

   assign in_ready = (CW'(DEPTH) - count) >= CW'(ENQ_W);
   assign do_enq   = in_ready && !flush;
   assign skip     = byp ? n_iss : '0;
   assign n_wr     = do_enq ? (n_in - skip) : '0;
   assign deq      = (stall || byp) ? '0 : n_iss;

   // lanes already issued through the bypass are not stored
   always_ff @(posedge clk) begin
      for (int j = 0; j < ENQ_W; j++) begin
         if (do_enq && CW'(j) >= skip && CW'(j) < n_in) begin
            mem_ir[tail + AW'(j) - skip[AW-1:0]] <= in_ir[j];
            mem_pc[tail + AW'(j) - skip[AW-1:0]] <= in_pc[j];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + deq[AW-1:0];
         tail  <= tail + n_wr[AW-1:0];
         count <= count + n_wr - deq;
      end
   end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed and random stimulus for issue_queue, checked against a queue-based reference model.
// The model follows ISSUEQ_BYPASS_EN the same way the design does.
module tb_issue_queue;
   localparam int ISSUE_W = 2, ENQ_W = 2, DEPTH = 8, PC_W = 8, IR_W = 16;
`ifdef ISSUEQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                         clk = 1'b0;
   logic                         rst, flush, stall;
   logic [ENQ_W-1:0]             in_valid;
   logic [ENQ_W-1:0][IR_W-1:0]   in_ir;
   logic [ENQ_W-1:0][PC_W-1:0]   in_pc;
   logic                         in_ready;
   logic [ISSUE_W-1:0]           out_valid;
   logic [ISSUE_W-1:0][IR_W-1:0] out_ir;
   logic [ISSUE_W-1:0][PC_W-1:0] out_pc;
   logic [$clog2(DEPTH):0]       count;

   always #5 clk = ~clk;

   issue_queue #(.ISSUE_W(ISSUE_W), .ENQ_W(ENQ_W), .DEPTH(DEPTH), .PC_W(PC_W), .IR_W(IR_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_ir(in_ir), .in_pc(in_pc), .in_ready(in_ready),
      .out_valid(out_valid), .out_ir(out_ir), .out_pc(out_pc), .count(count)
   );

   typedef struct packed { logic [15:0] ir; logic [7:0] pc; } ent_t;

   ent_t       q[$];
   int         n_chk = 0, n_pass = 0, pc_ctr = 0;
   bit         chk_en = 1'b0;
   logic [1:0] last_ov;
   logic [15:0] last_ir0;
   logic [3:0] last_cnt;
   logic       last_rdy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // register read/write sets as bitmasks over R0..R7
   function automatic void dec(input logic [15:0] ir, output logic [7:0] rd, output logic [7:0] wr,
                               output bit fl, output bit hl);
      rd = '0; wr = '0; fl = 1'b0; hl = 1'b0;
      casez ({ir[15:13], ir[12:11]})
         5'b110_10: wr[ir[10:8]] = 1'b1;
         5'b110_00: begin wr[ir[7:5]] = 1'b1; rd[ir[2:0]] = 1'b1; end
         5'b101_00, 5'b101_10: begin wr[ir[7:5]] = 1'b1; rd[ir[10:8]] = 1'b1; rd[ir[2:0]] = 1'b1; end
         5'b101_01: begin rd[ir[10:8]] = 1'b1; rd[ir[2:0]] = 1'b1; fl = 1'b1; end
         5'b101_11: begin wr[ir[7:5]] = 1'b1; rd[ir[2:0]] = 1'b1; end
         5'b011_00: begin wr[ir[7:5]] = 1'b1; rd[ir[10:8]] = 1'b1; end
         5'b100_00: begin rd[ir[10:8]] = 1'b1; rd[ir[7:5]] = 1'b1; end
         5'b111_??: hl = 1'b1;
         default: ;
      endcase
   endfunction

   // one clock: drive, check at the falling edge, then advance the model past the rising edge
   task automatic step(input logic s, input logic f, input logic r, input logic [1:0] v,
                       input logic [15:0] i0, input logic [15:0] i1);
      ent_t cand[ISSUE_W];
      int nc, n, nin, skip;
      logic [7:0] wacc, rd, wr;
      bit facc, hseen, fl, hl, byp, rdy;
      stall = s; flush = f; rst = r; in_valid = v;
      in_ir[0] = i0; in_ir[1] = i1;
      in_pc[0] = 8'(pc_ctr); in_pc[1] = 8'(pc_ctr + 1);
      pc_ctr += 2;
      nin = v[0] ? (v[1] ? 2 : 1) : 0;
      byp = BYP && q.size() == 0 && !s;
      nc = 0;
      if (byp) begin
         for (int j = 0; j < nin; j++) begin cand[nc] = {in_ir[j], in_pc[j]}; nc++; end
      end else begin
         for (int j = 0; j < ISSUE_W && j < q.size(); j++) begin cand[nc] = q[j]; nc++; end
      end
      n = 0; wacc = '0; facc = 1'b0; hseen = 1'b0;
      for (int k = 0; k < nc; k++) begin
         dec(cand[k].ir, rd, wr, fl, hl);
         if ((rd & wacc) != 0 || (wr & wacc) != 0 || (fl && facc) || hseen || (hl && k > 0)) break;
         n++; wacc |= wr; facc |= fl; hseen |= hl;
      end
      rdy = (DEPTH - q.size()) >= ENQ_W;
      @(negedge clk);
      if (chk_en) begin
         chk("count", 32'(count), q.size());
         chk("in_ready", 32'(in_ready), 32'(rdy));
         chk("out_valid", 32'(out_valid), (1 << n) - 1);
         for (int k = 0; k < n; k++) begin
            chk("out_ir", 32'(out_ir[k]), 32'(cand[k].ir));
            chk("out_pc", 32'(out_pc[k]), 32'(cand[k].pc));
         end
      end
      last_ov = out_valid; last_ir0 = out_ir[0]; last_cnt = count; last_rdy = in_ready;
      @(posedge clk);
      chk_en = 1'b1;
      if (!r || f) q.delete();
      else begin
         if (!s && !byp) repeat (n) void'(q.pop_front());
         if (rdy) begin
            skip = byp ? n : 0;
            for (int j = skip; j < nin; j++) q.push_back({in_ir[j], in_pc[j]});
         end
      end
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b1, 2'b00, 16'h0, 16'h0);
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = '0; in_ir = '0; in_pc = '0;
      @(posedge clk); #1;
      step(1'b0, 1'b0, 1'b0, 2'b11, 16'hD002, 16'hD102);
      step(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
      idle();
      chk("rst_cnt", 32'(last_cnt), 0);
      chk("rst_rdy", 32'(last_rdy), 1);
      chk("rst_ov", 32'(last_ov), 0);

      // independent MOVs pair up
      step(1'b0, 1'b0, 1'b1, 2'b11, 16'hD002, 16'hD102);
      chk("tp1_first_ov", 32'(last_ov), BYP ? 3 : 0);
      if (!BYP) idle();
      chk("tp1_ov", 32'(last_ov), 3);
      chk("tp1_ir0", 32'(last_ir0), 16'hD002);
      idle();
      chk("tp1_cnt", 32'(last_cnt), 0);

      // RAW on R3 splits the pair
      step(1'b0, 1'b0, 1'b1, 2'b11, 16'hA168, 16'hA143);
      if (!BYP) idle();
      chk("tp2_ov0", 32'(last_ov), 1);
      chk("tp2_ir0", 32'(last_ir0), 16'hA168);
      idle();
      chk("tp2_ov1", 32'(last_ov), 1);
      chk("tp2_ir1", 32'(last_ir0), 16'hA143);

      // two flag writers serialise; LDR+STR do not conflict
      step(1'b0, 1'b0, 1'b1, 2'b11, 16'hAC00, 16'hAD00);
      if (!BYP) idle();
      chk("tp3_cmp0", 32'(last_ir0), 16'hAC00);
      chk("tp3_ov0", 32'(last_ov), 1);
      idle();
      chk("tp3_cmp1", 32'(last_ir0), 16'hAD00);
      step(1'b0, 1'b0, 1'b1, 2'b11, 16'h61A0, 16'h8140);
      if (!BYP) idle();
      chk("tp3_ldst_ov", 32'(last_ov), 3);
      chk("tp3_ldst_ir", 32'(last_ir0), 16'h61A0);

      // offset the pointers so the fill below wraps
      step(1'b0, 1'b0, 1'b1, 2'b01, 16'h0000, 16'h0);
      idle();
      for (int i = 0; i < 5; i++)
         step(1'b1, 1'b0, 1'b1, 2'b11, 16'hD000 | 16'(((2 * i) % 8) << 8),
              16'hD000 | 16'(((2 * i + 1) % 8) << 8));
      chk("tp4_full_cnt", 32'(last_cnt), DEPTH);
      chk("tp4_full_rdy", 32'(last_rdy), 0);
      repeat (5) idle();
      chk("tp4_drained", 32'(last_cnt), 0);

      // flush with a same-cycle enqueue, then reset mid-stream
      step(1'b1, 1'b0, 1'b1, 2'b11, 16'h0000, 16'h0000);
      step(1'b1, 1'b0, 1'b1, 2'b11, 16'h0000, 16'h0000);
      step(1'b1, 1'b0, 1'b1, 2'b01, 16'h0000, 16'h0000);
      step(1'b1, 1'b1, 1'b1, 2'b11, 16'hD002, 16'hD102);
      chk("tp5_pre_flush", 32'(last_cnt), 5);
      step(1'b1, 1'b0, 1'b1, 2'b00, 16'h0, 16'h0);
      chk("tp5_flush_cnt", 32'(last_cnt), 0);
      chk("tp5_flush_ov", 32'(last_ov), 0);
      step(1'b1, 1'b0, 1'b1, 2'b11, 16'hD002, 16'hD102);
      step(1'b1, 1'b0, 1'b1, 2'b11, 16'hD302, 16'hD402);
      step(1'b0, 1'b0, 1'b0, 2'b11, 16'hD502, 16'hD602);
      idle();
      chk("tp5_rst_cnt", 32'(last_cnt), 0);
      chk("tp5_rst_rdy", 32'(last_rdy), 1);
      chk("tp5_rst_ov", 32'(last_ov), 0);

      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 59) != 0,
              2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
